dma_reg_file: RTL and testbench
===============================

// Module: dma_reg_file
// PURPOSE
//  DMA register bank behind the APB3 slave's register interface (i_clk domain): per-stream CR/NDTR/PAR/M0AR + global ISR/IFCR.
//  Drives stream configuration to the transfer engine; takes its per-beat/error events, counts NDTR down,
//  sets status flags, auto-disables or reloads streams, raises per-stream interrupts.
// PARAMETERS
//  STREAMS  8  number of DMA streams, 1..8 (ISR packs 4 bits/stream into 32 bits)
// PORTS
//  i_clk           in   1           single clock (register-interface and engine clock)
//  i_nreset        in   1           reset, asynchronous, active-low
//  i_addr          in   32          byte address; only [7:0] decoded, [1:0] ignored
//  i_read_en       in   1           read strobe, 1 cycle
//  i_write_en      in   1           write strobe, 1 cycle
//  i_byte_strobe   in   4           per-byte write enable
//  i_wdata         in   32          write data
//  o_rdata         out  32          read data, combinational from i_addr
//  i_beat_done     in   STREAMS     engine: one data item moved on stream n (1-cycle pulse)
//  i_xfer_err      in   STREAMS     engine: bus error on stream n (1-cycle pulse)
//  o_cr            out  STREAMS*32  CR of stream n at [32n+:32]
//  o_ndtr          out  STREAMS*16  live NDTR of stream n
//  o_par           out  STREAMS*32  peripheral address
//  o_m0ar          out  STREAMS*32  memory address
//  o_irq           out  STREAMS     level interrupt per stream
// BEHAVIOUR
//  Reset: all registers, flags, latched init counts = 0; o_rdata = 0 for any addr at reset; o_irq = 0.
//  Map: 0x00 ISR (RO), 0x04 IFCR (WO, reads 0); stream n base 0x10+0x10*n: +0 CR, +4 NDTR[15:0], +8 PAR, +C M0AR.
//   Unmapped / n>=STREAMS: reads 0, writes ignored.
//  Read: o_rdata valid combinationally same cycle as i_read_en (sampled by slave); no read side effects.
//  Write: byte-masked by i_byte_strobe, takes effect at next i_clk edge.
//  CR: [0]EN [1]TCIE [2]HTIE [3]TEIE [7:6]DIR [9:8]PSIZE [11:10]MSIZE [12]MINC [13]PINC [14]CIRC; other bits read 0.
//  ISR stream n bits [4n+:4]: [0]TCIF [1]HTIF [2]TEIF [3] reads 0. IFCR same layout, write-1-to-clear.
//  Per-stream state: IDLE (EN=0) / ACTIVE (EN=1).
//   IDLE->ACTIVE: CR write with EN=1 and NDTR!=0; if NDTR==0, EN stays 0, other CR bits written.
//   ACTIVE->IDLE: CR write EN=0 (NDTR holds); i_xfer_err (TEIF=1); NDTR 1->0 with CIRC=0 (TCIF=1).
//   NDTR 1->0 with CIRC=1: TCIF=1, NDTR reloads init count, stays ACTIVE.
//  NDTR/PAR/M0AR writes ignored while EN=1; CR writes while EN=1 affect only EN and TCIE/HTIE/TEIE.
//  NDTR write latches init count. i_beat_done in ACTIVE decrements NDTR by 1; ignored in IDLE.
//  HTIF set on the decrement giving NDTR == init>>1, only when init>=2.
//  i_xfer_err and i_beat_done same cycle: error wins, no decrement.
//  Flag set and IFCR clear same cycle: set wins.
//  o_irq[n] = (TCIF&TCIE)|(HTIF&HTIE)|(TEIF&TEIE), registered-flag based, no extra latency.
//  Async reset mid-transfer: all streams IDLE, counts/flags zeroed immediately.
// STRUCTURE
//  Package dma_reg_pkg: address offsets (ISR, IFCR, stream base/stride, CR/NDTR/PAR/M0AR), CR bit indices,
//   flag indices, typedef struct packed for CR, stream_state_e {IDLE, ACTIVE}.
//  Sub-module dma_stream_regs: one stream's CR/NDTR/PAR/M0AR/init count/flags/irq; generate x STREAMS.
//   Top holds address decode, ISR/IFCR packing, read mux.
// TESTING
//  Reset then read all mapped addrs -> all 0, o_irq=0.
//  S0: NDTR=4, PAR=0x4000_0000, CR=0x0007 (EN,TCIE,HTIE); 2 beats -> NDTR=2, HTIF, o_irq[0]=1;
//   IFCR=0x2 -> irq drops; 2 more beats -> NDTR=0, TCIF, EN=0, ISR=0x1.
//  S3 CIRC: NDTR=3, CR=EN|CIRC; 3 beats -> TCIF set, NDTR=3, EN=1; 4th beat -> NDTR=2.
//  S1 active: write PAR=0x1234, NDTR=9 -> unchanged; i_xfer_err with i_beat_done -> TEIF, EN=0, NDTR unchanged.
//  CR=EN with NDTR=0 -> EN reads 0; IFCR write same cycle as TC -> TCIF stays 1;
//   byte_strobe=4'b0001 PAR write -> only [7:0] changes.
//  Assert i_nreset mid-transfer on S2 -> all outputs 0 asynchronously; unmapped 0xFC reads 0.

Source files
------------

// File: rtl/dma_reg_pkg.sv
// Shared constants and types for the DMA register bank: address map, CR layout,
// flag positions and the byte-lane write helper.
package dma_reg_pkg;

  // Byte offsets; a stream's registers live at STREAM_BASE + n*STREAM_STRIDE
  localparam logic [7:0] ISR_OFFS      = 8'h00;
  localparam logic [7:0] IFCR_OFFS     = 8'h04;
  localparam logic [7:0] STREAM_BASE   = 8'h10;
  localparam logic [7:0] STREAM_STRIDE = 8'h10;

  // Word index of each register inside a stream block (offsets 0x0/0x4/0x8/0xC)
  localparam logic [1:0] REG_CR   = 2'd0;
  localparam logic [1:0] REG_NDTR = 2'd1;
  localparam logic [1:0] REG_PAR  = 2'd2;
  localparam logic [1:0] REG_M0AR = 2'd3;

  localparam int CR_EN   = 0;
  localparam int CR_TCIE = 1;
  localparam int CR_HTIE = 2;
  localparam int CR_TEIE = 3;
  localparam int CR_DIR  = 6;
  localparam int CR_PSIZE = 8;
  localparam int CR_MSIZE = 10;
  localparam int CR_MINC = 12;
  localparam int CR_PINC = 13;
  localparam int CR_CIRC = 14;

  localparam logic [31:0] CR_RW_MASK = 32'h0000_7FCF;

  localparam int TCIF_BIT = 0;
  localparam int HTIF_BIT = 1;
  localparam int TEIF_BIT = 2;
  localparam int FLAG_W   = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } stream_state_e;

  typedef struct packed {
    logic [16:0] rsvd_31_15;
    logic        circ;
    logic        pinc;
    logic        minc;
    logic [1:0]  msize;
    logic [1:0]  psize;
    logic [1:0]  dir;
    logic [1:0]  rsvd_5_4;
    logic        teie;
    logic        htie;
    logic        tcie;
    logic        en;
  } dma_cr_t;

  function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_reg_file_if.sv
// Register-interface bundle between the APB3 slave (master side) and the DMA register bank.
interface dma_reg_file_if;
  logic [31:0] i_addr;
  logic        i_read_en;
  logic        i_write_en;
  logic [3:0]  i_byte_strobe;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;

  modport master (
    output i_addr, i_read_en, i_write_en, i_byte_strobe, i_wdata,
    input  o_rdata
  );

  modport slave (
    input  i_addr, i_read_en, i_write_en, i_byte_strobe, i_wdata,
    output o_rdata
  );
endinterface

// File: rtl/dma_stream_regs.sv
// One DMA stream: CR/NDTR/PAR/M0AR, latched initial count, status flags and interrupt.
module dma_stream_regs
  import dma_reg_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_nreset,
  input  logic              i_wr_cr,
  input  logic              i_wr_ndtr,
  input  logic              i_wr_par,
  input  logic              i_wr_m0ar,
  input  logic [3:0]        i_byte_strobe,
  input  logic [31:0]       i_wdata,
  input  logic [FLAG_W-1:0] i_flag_clr,
  input  logic              i_beat_done,
  input  logic              i_xfer_err,
  output logic [31:0]       o_cr,
  output logic [15:0]       o_ndtr,
  output logic [31:0]       o_par,
  output logic [31:0]       o_m0ar,
  output logic [FLAG_W-1:0] o_flags,
  output logic              o_irq
);

  dma_cr_t           cr_q, cr_d, cr_wr;
  logic [15:0]       ndtr_q, ndtr_d, ndtr_dec, ndtr_wr;
  logic [15:0]       init_q, init_d;
  logic [31:0]       par_q, par_d;
  logic [31:0]       m0ar_q, m0ar_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  stream_state_e     state;

  assign state    = stream_state_e'(cr_q.en);
  assign cr_wr    = dma_cr_t'(apply_strobe(cr_q, i_wdata, i_byte_strobe) & CR_RW_MASK);
  assign ndtr_dec = ndtr_q - 16'd1;
  assign ndtr_wr  = {i_byte_strobe[1] ? i_wdata[15:8] : ndtr_q[15:8],
                     i_byte_strobe[0] ? i_wdata[7:0]  : ndtr_q[7:0]};

  always_comb begin
    cr_d    = cr_q;
    ndtr_d  = ndtr_q;
    init_d  = init_q;
    par_d   = par_q;
    m0ar_d  = m0ar_q;
    // Clear first so that a flag set in the same cycle takes precedence
    flags_d = flags_q & ~i_flag_clr;

    if (state == ACTIVE) begin
      if (i_xfer_err) begin
        flags_d[TEIF_BIT] = 1'b1;
        cr_d.en           = 1'b0;
      end else if (i_beat_done) begin
        ndtr_d = ndtr_dec;
        if ((init_q >= 16'd2) && (ndtr_dec == (init_q >> 1))) flags_d[HTIF_BIT] = 1'b1;
        if (ndtr_dec == 16'd0) begin
          flags_d[TCIF_BIT] = 1'b1;
          if (cr_q.circ) ndtr_d = init_q;
          else           cr_d.en = 1'b0;
        end
      end
    end

    if (i_wr_cr) begin
      if (state == ACTIVE) begin
        // An engine-driven disable in this cycle cannot be overridden by software
        cr_d.en   = cr_d.en & cr_wr.en;
        cr_d.tcie = cr_wr.tcie;
        cr_d.htie = cr_wr.htie;
        cr_d.teie = cr_wr.teie;
      end else begin
        cr_d    = cr_wr;
        cr_d.en = cr_wr.en & (ndtr_q != 16'd0);
      end
    end

    if (state == IDLE) begin
      if (i_wr_ndtr) begin
        ndtr_d = ndtr_wr;
        init_d = ndtr_wr;
      end
      if (i_wr_par)  par_d  = apply_strobe(par_q, i_wdata, i_byte_strobe);
      if (i_wr_m0ar) m0ar_d = apply_strobe(m0ar_q, i_wdata, i_byte_strobe);
    end
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      cr_q    <= '0;
      ndtr_q  <= '0;
      init_q  <= '0;
      par_q   <= '0;
      m0ar_q  <= '0;
      flags_q <= '0;
    end else begin
      cr_q    <= cr_d;
      ndtr_q  <= ndtr_d;
      init_q  <= init_d;
      par_q   <= par_d;
      m0ar_q  <= m0ar_d;
      flags_q <= flags_d;
    end
  end

  assign o_cr    = cr_q;
  assign o_ndtr  = ndtr_q;
  assign o_par   = par_q;
  assign o_m0ar  = m0ar_q;
  assign o_flags = flags_q;
  assign o_irq   = (flags_q[TCIF_BIT] & cr_q.tcie) |
                   (flags_q[HTIF_BIT] & cr_q.htie) |
                   (flags_q[TEIF_BIT] & cr_q.teie);

endmodule

// File: rtl/dma_reg_file.sv
// DMA register bank: address decode, ISR/IFCR packing and read mux around
// STREAMS instances of dma_stream_regs.
module dma_reg_file
  import dma_reg_pkg::*;
#(
  parameter int STREAMS = 8
)
(
  input  logic                 i_clk,
  input  logic                 i_nreset,
  dma_reg_file_if.slave        bus,
  input  logic [STREAMS-1:0]   i_beat_done,
  input  logic [STREAMS-1:0]   i_xfer_err,
  output logic [STREAMS*32-1:0] o_cr,
  output logic [STREAMS*16-1:0] o_ndtr,
  output logic [STREAMS*32-1:0] o_par,
  output logic [STREAMS*32-1:0] o_m0ar,
  output logic [STREAMS-1:0]   o_irq
);

  logic [5:0]        word_idx;
  logic [31:0]       lane_mask;
  logic              ifcr_wr;
  logic [31:0]       clr_word;
  logic [31:0]       isr;
  logic [31:0]       rdata_c;
  logic [STREAMS-1:0] stream_sel;
  logic [31:0]       cr_a   [STREAMS];
  logic [15:0]       ndtr_a [STREAMS];
  logic [31:0]       par_a  [STREAMS];
  logic [31:0]       m0ar_a [STREAMS];
  logic [FLAG_W-1:0] flags_a[STREAMS];
  logic              unused_bits;

  assign word_idx = bus.i_addr[7:2];

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < 4; b++) lane_mask[8*b +: 8] = {8{bus.i_byte_strobe[b]}};
  end

  assign ifcr_wr  = bus.i_write_en && (word_idx == IFCR_OFFS[7:2]);
  assign clr_word = ifcr_wr ? (bus.i_wdata & lane_mask) : 32'h0;

  generate
    for (genvar gi = 0; gi < STREAMS; gi++) begin : g_stream
      localparam logic [7:0] BASE = 8'(STREAM_BASE + STREAM_STRIDE * gi);

      assign stream_sel[gi] = (word_idx[5:2] == BASE[7:4]);

      dma_stream_regs u_stream (
        .i_clk         (i_clk),
        .i_nreset      (i_nreset),
        .i_wr_cr       (bus.i_write_en && stream_sel[gi] && (word_idx[1:0] == REG_CR)),
        .i_wr_ndtr     (bus.i_write_en && stream_sel[gi] && (word_idx[1:0] == REG_NDTR)),
        .i_wr_par      (bus.i_write_en && stream_sel[gi] && (word_idx[1:0] == REG_PAR)),
        .i_wr_m0ar     (bus.i_write_en && stream_sel[gi] && (word_idx[1:0] == REG_M0AR)),
        .i_byte_strobe (bus.i_byte_strobe),
        .i_wdata       (bus.i_wdata),
        .i_flag_clr    (clr_word[4*gi +: FLAG_W]),
        .i_beat_done   (i_beat_done[gi]),
        .i_xfer_err    (i_xfer_err[gi]),
        .o_cr          (cr_a[gi]),
        .o_ndtr        (ndtr_a[gi]),
        .o_par         (par_a[gi]),
        .o_m0ar        (m0ar_a[gi]),
        .o_flags       (flags_a[gi]),
        .o_irq         (o_irq[gi])
      );

      assign o_cr  [32*gi +: 32] = cr_a[gi];
      assign o_ndtr[16*gi +: 16] = ndtr_a[gi];
      assign o_par [32*gi +: 32] = par_a[gi];
      assign o_m0ar[32*gi +: 32] = m0ar_a[gi];
    end

    // ISR always spans eight nibbles; absent streams read as zero
    for (genvar gi = 0; gi < 8; gi++) begin : g_isr
      if (gi < STREAMS) begin : g_live
        assign isr[4*gi +: 4] = {1'b0, flags_a[gi]};
      end else begin : g_absent
        assign isr[4*gi +: 4] = 4'h0;
      end
    end
  endgenerate

  always_comb begin
    rdata_c = '0;
    if (word_idx == ISR_OFFS[7:2]) rdata_c = isr;
    for (int n = 0; n < STREAMS; n++) begin
      if (stream_sel[n]) begin
        case (word_idx[1:0])
          REG_CR:   rdata_c = cr_a[n];
          REG_NDTR: rdata_c = {16'h0, ndtr_a[n]};
          REG_PAR:  rdata_c = par_a[n];
          default:  rdata_c = m0ar_a[n];
        endcase
      end
    end
  end

  assign bus.o_rdata = rdata_c;

  // Address bits outside the decoded window and the read strobe carry no state
  assign unused_bits = ^{bus.i_addr[31:8], bus.i_addr[1:0], bus.i_read_en, clr_word};

endmodule

// File: tb/tb_dma_reg_file.sv
// Directed self-checking bench for dma_reg_file: one task per feature, inline comparisons.
module tb_dma_reg_file;
  localparam int STREAMS = 8;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic [STREAMS-1:0]    beat = '0;
  logic [STREAMS-1:0]    err  = '0;
  logic [STREAMS*32-1:0] cr, par, m0ar;
  logic [STREAMS*16-1:0] ndtr;
  logic [STREAMS-1:0]    irq;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dma_reg_file_if bus ();

  dma_reg_file #(.STREAMS(STREAMS)) dut (
    .i_clk       (clk),
    .i_nreset    (nreset),
    .bus         (bus),
    .i_beat_done (beat),
    .i_xfer_err  (err),
    .o_cr        (cr),
    .o_ndtr      (ndtr),
    .o_par       (par),
    .o_m0ar      (m0ar),
    .o_irq       (irq)
  );

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    bus.i_addr = a; bus.i_wdata = d; bus.i_byte_strobe = s; bus.i_write_en = 1'b1;
    @(negedge clk);
    bus.i_write_en = 1'b0; bus.i_byte_strobe = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.i_addr = a; bus.i_read_en = 1'b1;
    #1 d = bus.o_rdata;
    bus.i_read_en = 1'b0;
  endtask

  task automatic pulse(input logic [STREAMS-1:0] b, input logic [STREAMS-1:0] e);
    @(negedge clk);
    beat = b; err = e;
    @(negedge clk);
    beat = '0; err = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.i_addr = '0; bus.i_wdata = '0; bus.i_byte_strobe = '0;
    bus.i_write_en = 1'b0; bus.i_read_en = 1'b0;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    for (int a = 0; a <= 32'h8C; a += 4) begin
      rd(32'(a), d);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_read addr=%h got %h exp 0", a, d); end
    end
    checks++; if (irq !== 8'h00) begin fails++; $display("FAIL reset_irq got %h exp 00", irq); end
    $display("test_reset: reads of all mapped addresses done");
  endtask

  task automatic test_s0_basic();
    logic [31:0] d;
    wr(32'h14, 32'd4, 4'hF);
    wr(32'h18, 32'h4000_0000, 4'hF);
    wr(32'h10, 32'h0000_0007, 4'hF);
    rd(32'h10, d);
    checks++; if (d !== 32'h7) begin fails++; $display("FAIL s0_cr_en got %h exp 00000007", d); end
    rd(32'h18, d);
    checks++; if (d !== 32'h4000_0000) begin fails++; $display("FAIL s0_par got %h exp 40000000", d); end
    pulse(8'h01, 8'h00);
    pulse(8'h01, 8'h00);
    rd(32'h14, d);
    checks++; if (d !== 32'd2) begin fails++; $display("FAIL s0_ndtr_half got %h exp 2", d); end
    rd(32'h00, d);
    checks++; if (d !== 32'h2) begin fails++; $display("FAIL s0_isr_ht got %h exp 00000002", d); end
    checks++; if (irq !== 8'h01) begin fails++; $display("FAIL s0_irq_ht got %h exp 01", irq); end
    wr(32'h04, 32'h2, 4'hF);
    #1;
    checks++; if (irq !== 8'h00) begin fails++; $display("FAIL s0_irq_cleared got %h exp 00", irq); end
    pulse(8'h01, 8'h00);
    pulse(8'h01, 8'h00);
    checks++; if (ndtr[15:0] !== 16'd0) begin fails++; $display("FAIL s0_ndtr_done got %h exp 0", ndtr[15:0]); end
    rd(32'h00, d);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL s0_isr_tc got %h exp 00000001", d); end
    rd(32'h10, d);
    checks++; if (d !== 32'h6) begin fails++; $display("FAIL s0_cr_autodis got %h exp 00000006", d); end
    checks++; if (irq !== 8'h01) begin fails++; $display("FAIL s0_irq_tc got %h exp 01", irq); end
    wr(32'h04, 32'h1, 4'hF);
    $display("test_s0_basic: half/complete transfer on stream 0 done");
  endtask

  task automatic test_circ();
    logic [31:0] d;
    wr(32'h44, 32'd3, 4'hF);
    wr(32'h40, 32'h0000_4001, 4'hF);
    repeat (3) pulse(8'h08, 8'h00);
    rd(32'h00, d);
    checks++; if (d !== 32'h0000_3000) begin fails++; $display("FAIL circ_isr got %h exp 00003000", d); end
    rd(32'h44, d);
    checks++; if (d !== 32'd3) begin fails++; $display("FAIL circ_reload got %h exp 3", d); end
    rd(32'h40, d);
    checks++; if (d !== 32'h0000_4001) begin fails++; $display("FAIL circ_still_en got %h exp 00004001", d); end
    pulse(8'h08, 8'h00);
    rd(32'h44, d);
    checks++; if (d !== 32'd2) begin fails++; $display("FAIL circ_next_beat got %h exp 2", d); end
    wr(32'h40, 32'h0, 4'hF);
    rd(32'h40, d);
    checks++; if (d !== 32'h0000_4000) begin fails++; $display("FAIL circ_disable got %h exp 00004000", d); end
    wr(32'h04, 32'h0000_3000, 4'hF);
    $display("test_circ: circular reload on stream 3 done");
  endtask

  task automatic test_boundaries();
    logic [31:0] d;
    wr(32'h50, 32'h0000_0041, 4'hF);
    rd(32'h50, d);
    checks++; if (d !== 32'h0000_0040) begin fails++; $display("FAIL en_ndtr0 got %h exp 00000040", d); end
    wr(32'h64, 32'd1, 4'hF);
    wr(32'h60, 32'h1, 4'hF);
    @(negedge clk);
    beat = 8'h20;
    bus.i_addr = 32'h04; bus.i_wdata = 32'h0010_0000; bus.i_byte_strobe = 4'hF; bus.i_write_en = 1'b1;
    @(negedge clk);
    beat = '0; bus.i_write_en = 1'b0; bus.i_byte_strobe = 4'h0;
    rd(32'h00, d);
    checks++; if (d !== 32'h0010_0000) begin fails++; $display("FAIL set_wins_clear got %h exp 00100000", d); end
    rd(32'h60, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL s5_autodis got %h exp 0", d); end
    wr(32'h04, 32'h0010_0000, 4'hF);
    rd(32'h00, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL ifcr_clear got %h exp 0", d); end
    wr(32'h78, 32'h1122_3344, 4'hF);
    wr(32'h78, 32'hAABB_CCDD, 4'b0001);
    rd(32'h78, d);
    checks++; if (d !== 32'h1122_33DD) begin fails++; $display("FAIL byte_strobe got %h exp 112233DD", d); end
    wr(32'h08, 32'hFFFF_FFFF, 4'hF);
    rd(32'h08, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_08 got %h exp 0", d); end
    rd(32'hFC, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_fc got %h exp 0", d); end
    rd(32'h04, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL ifcr_read got %h exp 0", d); end
    $display("test_boundaries: NDTR=0 enable, set-vs-clear, byte strobe, unmapped done");
  endtask

  task automatic test_active_s1();
    logic [31:0] d;
    wr(32'h24, 32'd5, 4'hF);
    wr(32'h28, 32'hAAAA_0000, 4'hF);
    wr(32'h20, 32'h0000_0009, 4'hF);
    wr(32'h28, 32'h0000_1234, 4'hF);
    rd(32'h28, d);
    checks++; if (d !== 32'hAAAA_0000) begin fails++; $display("FAIL s1_par_locked got %h exp AAAA0000", d); end
    wr(32'h24, 32'd9, 4'hF);
    rd(32'h24, d);
    checks++; if (d !== 32'd5) begin fails++; $display("FAIL s1_ndtr_locked got %h exp 5", d); end
    wr(32'h20, 32'h0000_7FCF, 4'hF);
    rd(32'h20, d);
    checks++; if (d !== 32'h0000_000F) begin fails++; $display("FAIL s1_cr_active_wr got %h exp 0000000F", d); end
    pulse(8'h02, 8'h02);
    rd(32'h00, d);
    checks++; if (d !== 32'h0000_0040) begin fails++; $display("FAIL s1_teif got %h exp 00000040", d); end
    rd(32'h20, d);
    checks++; if (d !== 32'h0000_000E) begin fails++; $display("FAIL s1_err_dis got %h exp 0000000E", d); end
    rd(32'h24, d);
    checks++; if (d !== 32'd5) begin fails++; $display("FAIL s1_err_no_dec got %h exp 5", d); end
    checks++; if (irq !== 8'h02) begin fails++; $display("FAIL s1_irq got %h exp 02", irq); end
    $display("test_active_s1: active write lock and error priority done");
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(32'h34, 32'd10, 4'hF);
    wr(32'h38, 32'h55, 4'hF);
    wr(32'h3C, 32'h2000_0000, 4'hF);
    wr(32'h30, 32'h1, 4'hF);
    pulse(8'h04, 8'h00);
    rd(32'h34, d);
    checks++; if (d !== 32'd9) begin fails++; $display("FAIL s2_pre_reset got %h exp 9", d); end
    @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    checks++; if (cr !== '0) begin fails++; $display("FAIL areset_cr got %h exp 0", cr); end
    checks++; if (ndtr !== '0) begin fails++; $display("FAIL areset_ndtr got %h exp 0", ndtr); end
    checks++; if (par !== '0) begin fails++; $display("FAIL areset_par got %h exp 0", par); end
    checks++; if (m0ar !== '0) begin fails++; $display("FAIL areset_m0ar got %h exp 0", m0ar); end
    checks++; if (irq !== '0) begin fails++; $display("FAIL areset_irq got %h exp 0", irq); end
    checks++; if (bus.o_rdata !== 32'h0) begin fails++; $display("FAIL areset_rdata got %h exp 0", bus.o_rdata); end
    @(negedge clk);
    nreset = 1'b1;
    rd(32'h00, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL areset_isr got %h exp 0", d); end
    $display("test_async_reset: mid-transfer reset on stream 2 done");
  endtask

  initial begin
    test_reset();
    test_s0_basic();
    test_circ();
    test_boundaries();
    test_active_s1();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
